// File: rtl/aline_receive_fsm.sv
// aline_receive_fsm
// Receive-side A-line controller. After the transmitter reports completion it
// waits a programmable blanking interval, then captures record_length
// multi-channel ADC words into a small FIFO and streams them out on a
// valid/ready interface. Samples arriving while the FIFO is full are dropped,
// keep their index (so the consumer sees a gap), and set a sticky overflow
// flag. A one-cycle receive_complete pulse tells the sequencer the A-line is
// finished.

module aline_receive_fsm #(
    parameter int num_channels   = 8,
    parameter int sample_width   = 12,
    parameter int count_num_bits = 16,
    parameter int fifo_depth     = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   transmit_complete,
    input  logic                                   abort,
    input  logic [count_num_bits-1:0]              blank_cycles,
    input  logic [count_num_bits-1:0]              record_length,
    input  logic [num_channels*sample_width-1:0]   adc_data,
    input  logic                                   adc_valid,
    output logic [num_channels*sample_width-1:0]   out_data,
    output logic [count_num_bits-1:0]              out_index,
    output logic                                   out_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   receive_in_progress,
    output logic                                   receive_complete,
    output logic                                   overflow
);

    // ------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------
    localparam int data_width  = num_channels * sample_width;
    localparam int ptr_width   = (fifo_depth > 2) ? $clog2(fifo_depth) : 1;
    localparam int entry_width = data_width + count_num_bits + 1;

    localparam logic [2:0] RX_IDLE    = 3'd0;
    localparam logic [2:0] RX_BLANK   = 3'd1;
    localparam logic [2:0] RX_CAPTURE = 3'd2;
    localparam logic [2:0] RX_DRAIN   = 3'd3;
    localparam logic [2:0] RX_DONE    = 3'd4;

    localparam logic [count_num_bits-1:0] cnt_zero  = {count_num_bits{1'b0}};
    localparam logic [count_num_bits-1:0] cnt_one   = count_num_bits'(1'b1);
    localparam logic [ptr_width-1:0]      ptr_zero  = {ptr_width{1'b0}};
    localparam logic [ptr_width-1:0]      ptr_one   = ptr_width'(1'b1);
    localparam logic [ptr_width:0]        fill_zero = {(ptr_width+1){1'b0}};
    localparam logic [ptr_width:0]        fill_one  = (ptr_width+1)'(1'b1);
    localparam logic [ptr_width:0]        fill_full = (ptr_width+1)'(fifo_depth);
    localparam logic [data_width-1:0]     data_zero = {data_width{1'b0}};
    localparam logic [entry_width-1:0]    entry_zero = {entry_width{1'b0}};

    // ------------------------------------------------------------------
    // State, counters and FIFO storage
    // ------------------------------------------------------------------
    logic [2:0]                state_r;
    logic [2:0]                state_n;
    logic [count_num_bits-1:0] blank_cnt_r;
    logic [count_num_bits-1:0] blank_cnt_n;
    logic [count_num_bits-1:0] len_r;
    logic [count_num_bits-1:0] len_n;
    logic [count_num_bits-1:0] sample_cnt_r;
    logic [count_num_bits-1:0] sample_cnt_n;
    logic                      overflow_r;
    logic                      overflow_n;
    logic                      in_progress_r;
    logic                      complete_r;

    logic [entry_width-1:0]    mem_r [fifo_depth];
    logic [ptr_width-1:0]      wr_ptr_r;
    logic [ptr_width-1:0]      wr_ptr_n;
    logic [ptr_width-1:0]      rd_ptr_r;
    logic [ptr_width-1:0]      rd_ptr_n;
    logic [ptr_width:0]        fill_r;
    logic [ptr_width:0]        fill_n;

    logic                      out_valid_r;
    logic [data_width-1:0]     out_data_r;
    logic [count_num_bits-1:0] out_index_r;
    logic                      out_last_r;

    // Combinational helpers
    logic                      capture_s;
    logic                      flush_s;
    logic                      pop_s;
    logic                      push_ok_s;
    logic                      push_s;
    logic                      is_last_s;
    logic [count_num_bits-1:0] last_index_s;
    logic [entry_width-1:0]    push_entry_s;
    logic                      head_from_push_s;
    logic [entry_width-1:0]    head_entry_s;

    // The head register always mirrors "fifo non-empty", so a pop is simply
    // a handshake on the registered head.
    assign pop_s        = out_valid_r && out_ready;
    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign push_ok_s    = (fill_r != fill_full) || pop_s;
    assign push_s       = capture_s && push_ok_s;
    assign last_index_s = len_r - cnt_one;
    assign is_last_s    = (sample_cnt_r == last_index_s);
    assign push_entry_s = {adc_data, sample_cnt_r, is_last_s};

    // Receive sequencing: arm, blank, capture, drain, done, with abort override.
    always_comb begin
        state_n      = state_r;
        blank_cnt_n  = blank_cnt_r;
        len_n        = len_r;
        sample_cnt_n = sample_cnt_r;
        overflow_n   = overflow_r;
        capture_s    = 1'b0;
        flush_s      = 1'b0;
        if (abort && (state_r != RX_IDLE)) begin
            // Abort discards everything; overflow deliberately survives so
            // the sequencer can still see that the aborted line was lossy.
            state_n = RX_IDLE;
            flush_s = 1'b1;
        end else begin
            case (state_r)
                RX_IDLE: begin
                    if (transmit_complete) begin
                        len_n        = record_length;
                        overflow_n   = 1'b0;
                        sample_cnt_n = cnt_zero;
                        blank_cnt_n  = blank_cycles;
                        if (record_length == cnt_zero) begin
                            state_n = RX_DONE;
                        end else begin
                            state_n = RX_BLANK;
                        end
                    end else begin
                        state_n = RX_IDLE;
                    end
                end
                RX_BLANK: begin
                    // ADC is ignored here; the counter stops at zero so it
                    // cannot underflow.
                    if (blank_cnt_r == cnt_zero) begin
                        state_n = RX_CAPTURE;
                    end else begin
                        blank_cnt_n = blank_cnt_r - cnt_one;
                    end
                end
                RX_CAPTURE: begin
                    if (adc_valid) begin
                        capture_s    = 1'b1;
                        sample_cnt_n = sample_cnt_r + cnt_one;
                        if (!push_ok_s) begin
                            overflow_n = 1'b1;
                        end else begin
                            overflow_n = overflow_r;
                        end
                        if (is_last_s) begin
                            state_n = RX_DRAIN;
                        end else begin
                            state_n = RX_CAPTURE;
                        end
                    end else begin
                        state_n = RX_CAPTURE;
                    end
                end
                RX_DRAIN: begin
                    if (fill_r == fill_zero) begin
                        state_n = RX_DONE;
                    end else begin
                        state_n = RX_DRAIN;
                    end
                end
                RX_DONE: begin
                    state_n = RX_IDLE;
                end
                default: begin
                    state_n = RX_IDLE;
                end
            endcase
        end
    end

    // FIFO pointer and fill-level bookkeeping.
    always_comb begin
        wr_ptr_n = wr_ptr_r;
        rd_ptr_n = rd_ptr_r;
        fill_n   = fill_r;
        if (flush_s) begin
            wr_ptr_n = ptr_zero;
            rd_ptr_n = ptr_zero;
            fill_n   = fill_zero;
        end else begin
            if (push_s) begin
                wr_ptr_n = wr_ptr_r + ptr_one;
            end else begin
                wr_ptr_n = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_n = rd_ptr_r + ptr_one;
            end else begin
                rd_ptr_n = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fill_n = fill_r + fill_one;
                2'b01:   fill_n = fill_r - fill_one;
                default: fill_n = fill_r;
            endcase
        end
    end

    // Next head word: bypass the incoming word when the FIFO would otherwise
    // be empty, so an accepted sample reaches out_valid on the next cycle.
    always_comb begin
        head_from_push_s = 1'b0;
        head_entry_s     = mem_r[rd_ptr_n];
        if (push_s && ((fill_r == fill_zero) || ((fill_r == fill_one) && pop_s))) begin
            head_from_push_s = 1'b1;
            head_entry_s     = push_entry_s;
        end else begin
            head_from_push_s = 1'b0;
            head_entry_s     = mem_r[rd_ptr_n];
        end
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= RX_IDLE;
            blank_cnt_r   <= cnt_zero;
            len_r         <= cnt_zero;
            sample_cnt_r  <= cnt_zero;
            overflow_r    <= 1'b0;
            in_progress_r <= 1'b0;
            complete_r    <= 1'b0;
        end else begin
            state_r       <= state_n;
            blank_cnt_r   <= blank_cnt_n;
            len_r         <= len_n;
            sample_cnt_r  <= sample_cnt_n;
            overflow_r    <= overflow_n;
            in_progress_r <= (state_n == RX_BLANK) || (state_n == RX_CAPTURE) ||
                             (state_n == RX_DRAIN);
            complete_r    <= (state_n == RX_DONE);
        end
    end

    // FIFO storage, pointers and the registered head word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < fifo_depth; i++) begin
                mem_r[i] <= entry_zero;
            end
            wr_ptr_r    <= ptr_zero;
            rd_ptr_r    <= ptr_zero;
            fill_r      <= fill_zero;
            out_valid_r <= 1'b0;
            out_data_r  <= data_zero;
            out_index_r <= cnt_zero;
            out_last_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_entry_s;
            end else begin
                mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
            end
            wr_ptr_r    <= wr_ptr_n;
            rd_ptr_r    <= rd_ptr_n;
            fill_r      <= fill_n;
            out_valid_r <= (fill_n != fill_zero);
            if (fill_n != fill_zero) begin
                out_data_r  <= head_entry_s[entry_width-1 -: data_width];
                out_index_r <= head_entry_s[count_num_bits:1];
                out_last_r  <= head_entry_s[0];
            end else begin
                out_data_r  <= out_data_r;
                out_index_r <= out_index_r;
                out_last_r  <= 1'b0;
            end
        end
    end

    assign out_data            = out_data_r;
    assign out_index           = out_index_r;
    assign out_last            = out_last_r;
    assign out_valid           = out_valid_r;
    assign receive_in_progress = in_progress_r;
    assign receive_complete    = complete_r;
    assign overflow            = overflow_r;

endmodule
